// File: rtl/lvm16_pkg.sv
// Shared definitions for the lvm-16 core: opcodes, ALU function codes and
// instruction field positions.
package lvm16_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_AND  = 4'd2,
        FN_OR   = 4'd3,
        FN_XOR  = 4'd4,
        FN_NOT  = 4'd5,
        FN_SHL  = 4'd6,
        FN_SHR  = 4'd7,
        FN_PASS = 4'd8,
        FN_INC  = 4'd9,
        FN_DEC  = 4'd10
    } alu_fn_e;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 14;
    localparam int D_BIT    = 13;
    localparam int IMM_HI   = 12;
    localparam int F_HI     = 13;
    localparam int F_LO     = 10;
    localparam int W1_BIT   = 9;
    localparam int W2_BIT   = 8;
    localparam int ASEL_BIT = 7;
    localparam int BSEL_BIT = 6;
    localparam int JMP_HI   = 5;
    localparam int JMP_LO   = 3;

endpackage

// File: rtl/lvm16_alu.sv
// Combinational 16-bit ALU with signed lt/eq/gt flags on the result.
module lvm16_alu
    import lvm16_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       f_i,
    output logic [WIDTH-1:0] res_o,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    always_comb begin
        res_o = '0;
        case (f_i)
            FN_ADD:  res_o = a_i + b_i;
            FN_SUB:  res_o = a_i - b_i;
            FN_AND:  res_o = a_i & b_i;
            FN_OR:   res_o = a_i | b_i;
            FN_XOR:  res_o = a_i ^ b_i;
            FN_NOT:  res_o = ~a_i;
            FN_SHL:  res_o = {a_i[WIDTH-2:0], 1'b0};
            FN_SHR:  res_o = {1'b0, a_i[WIDTH-1:1]};
            FN_PASS: res_o = a_i;
            FN_INC:  res_o = a_i + 16'd1;
            FN_DEC:  res_o = a_i - 16'd1;
            default: res_o = '0;
        endcase
    end

    assign lt_o = res_o[WIDTH-1];
    assign eq_o = (res_o == '0);
    assign gt_o = !res_o[WIDTH-1] && (res_o != '0);

endmodule

// File: rtl/lvm16_cpu.sv
// lvm-16 single-cycle accumulator CPU: decode, r1/r2/pc registers and
// next-pc selection around the lvm16_alu datapath.
module lvm16_cpu
    import lvm16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] addr,
    output logic             write
);

    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic [WIDTH-1:0] pc_q, pc_d;

    logic [1:0]        op;
    logic              d_sel;
    logic [IMM_HI:0]   imm;
    logic [3:0]        fn;
    logic              w1, w2, asel, bsel;
    logic [2:0]        jmp;
    logic              unused_rsvd;

    assign op          = instruction[OP_HI:OP_LO];
    assign d_sel       = instruction[D_BIT];
    assign imm         = instruction[IMM_HI:0];
    assign fn          = instruction[F_HI:F_LO];
    assign w1          = instruction[W1_BIT];
    assign w2          = instruction[W2_BIT];
    assign asel        = instruction[ASEL_BIT];
    assign bsel        = instruction[BSEL_BIT];
    assign jmp         = instruction[JMP_HI:JMP_LO];
    assign unused_rsvd = ^instruction[2:0];

    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic             alu_lt, alu_eq, alu_gt;

    assign alu_a = asel ? r2_q : r1_q;
    assign alu_b = bsel ? data : r2_q;

    lvm16_alu u_alu (
        .a_i   (alu_a),
        .b_i   (alu_b),
        .f_i   (fn),
        .res_o (alu_res),
        .lt_o  (alu_lt),
        .eq_o  (alu_eq),
        .gt_o  (alu_gt)
    );

    logic             r1_en, r2_en, jump_taken;
    logic [WIDTH-1:0] wr_val;

    always_comb begin
        r1_en      = 1'b0;
        r2_en      = 1'b0;
        wr_val     = '0;
        out        = '0;
        write      = 1'b0;
        jump_taken = 1'b0;
        case (op)
            OP_LDI: begin
                wr_val = {3'b000, imm};
                r1_en  = !d_sel;
                r2_en  = d_sel;
            end
            OP_LD: begin
                wr_val = data;
                r1_en  = !d_sel;
                r2_en  = d_sel;
            end
            OP_ST: begin
                out   = d_sel ? r2_q : r1_q;
                write = 1'b1;
            end
            OP_ALU: begin
                out        = alu_res;
                wr_val     = alu_res;
                r1_en      = w1;
                r2_en      = w2;
                jump_taken = (jmp[2] & alu_lt) | (jmp[1] & alu_eq) | (jmp[0] & alu_gt);
            end
            default: ;
        endcase
    end

    assign r1_d = r1_en ? wr_val : r1_q;
    assign r2_d = r2_en ? wr_val : r2_q;
    // Jump target is the pre-edge r2, so a same-cycle w2 does not affect it.
    assign pc_d = jump_taken ? r2_q : pc_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1_q <= '0;
            r2_q <= '0;
            pc_q <= '0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
            pc_q <= pc_d;
        end
    end

    assign pc   = pc_q;
    assign addr = r1_q;

endmodule

// File: tb/tb_lvm16_cpu.sv
// Directed-vector bench for lvm16_cpu with hand-computed expectations.
module tb_lvm16_cpu;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [15:0] data;
    logic [15:0] out;
    logic [15:0] pc;
    logic [15:0] addr;
    logic        write;

    int n_checks;
    int n_errors;
    logic [15:0] exp_pc;

    lvm16_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .data        (data),
        .out         (out),
        .pc          (pc),
        .addr        (addr),
        .write       (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Drive a new instruction/data pair shortly after the active edge, let it settle.
    task automatic drive(input logic [15:0] ins, input logic [15:0] dat);
        instruction = ins;
        data        = dat;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] alu_ins(input logic [3:0] f, input logic w1, input logic w2,
                                            input logic asel, input logic bsel, input logic [2:0] jmp);
        return {2'b11, f, w1, w2, asel, bsel, jmp, 3'b000};
    endfunction

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        instruction = 16'h0000;
        data        = 16'h0000;

        // Held in reset across several edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc",    pc, 16'h0000);
        check("rst_addr",  addr, 16'h0000);
        check("rst_r2",    dut.r2_q, 16'h0000);
        check("rst_write", {15'd0, write}, 16'h0000);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("pc_count%0d", i), pc, 16'(i));
        end
        exp_pc = 16'd3;

        // LDI r1 / LDI r2
        drive(16'h0005, 16'h0000); tick(); exp_pc++;
        check("ldi_r1_addr", addr, 16'h0005);
        drive(16'h2007, 16'h0000); tick(); exp_pc++;
        check("ldi_r2", dut.r2_q, 16'h0007);
        check("ldi_r2_r1kept", addr, 16'h0005);

        // LD r1 / LD r2
        drive(16'h4000, 16'd50);
        check("ld_write", {15'd0, write}, 16'h0000);
        check("ld_out", out, 16'h0000);
        tick(); exp_pc++;
        check("ld_r1_addr", addr, 16'd50);
        drive(16'h6FFF, 16'd5); tick(); exp_pc++;
        check("ld_r2", dut.r2_q, 16'd5);
        check("pc_seq", pc, exp_pc);

        // SUB r1 = r1 - r2, no jump
        drive(alu_ins(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000), 16'h0000);
        check("sub_out", out, 16'd45);
        check("sub_write", {15'd0, write}, 16'h0000);
        tick(); exp_pc++;
        check("sub_r1", addr, 16'd45);
        check("sub_pc", pc, exp_pc);

        // Jump on eq: r1=r2=3, SUB w1 jmp=eq -> pc <= 3, r1 = 0
        drive(16'h0003, 16'h0000); tick();
        drive(16'h2003, 16'h0000); tick();
        drive(16'hC610, 16'h0000);
        check("jeq_out", out, 16'h0000);
        tick(); exp_pc = 16'd3;
        check("jeq_pc", pc, exp_pc);
        check("jeq_r1", addr, 16'h0000);

        // ST r2 with r1 = 0x0010, r2 = 0xBEEF
        drive(16'h0010, 16'h0000); tick();
        drive(16'h6000, 16'hBEEF); tick(); exp_pc = 16'd5;
        drive(16'hA000, 16'h1234);
        check("st_write", {15'd0, write}, 16'h0001);
        check("st_out", out, 16'hBEEF);
        check("st_addr", addr, 16'h0010);
        tick(); exp_pc++;
        check("st_r1_kept", addr, 16'h0010);
        check("st_r2_kept", dut.r2_q, 16'hBEEF);
        check("st_pc", pc, exp_pc);
        drive(16'h8000, 16'h0000);
        check("st_r1_out", out, 16'h0010);

        // NOT r1, no register writes
        drive(alu_ins(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), 16'h0000);
        check("not_out", out, 16'hFFEF);
        tick(); exp_pc++;
        check("not_nowr", addr, 16'h0010);

        // INC r2 into both regs, jump on lt to the old r2 value
        drive(alu_ins(4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100), 16'h0000);
        check("inc_out", out, 16'hBEF0);
        tick(); exp_pc = 16'hBEEF;
        check("inc_jlt_pc", pc, exp_pc);
        check("inc_r1", addr, 16'hBEF0);
        check("inc_r2", dut.r2_q, 16'hBEF0);

        // ADD r1 + data wraps to zero; gt jump not taken
        drive(alu_ins(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001), 16'h4110);
        check("add_wrap_out", out, 16'h0000);
        tick(); exp_pc++;
        check("add_wrap_r1", addr, 16'h0000);
        check("add_nojump_pc", pc, exp_pc);

        // Function sweep on a = r2 = 0xBEF0, b = r2
        drive(alu_ins(4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000), 16'h0000);
        check("shl_out", out, 16'h7DE0);
        drive(alu_ins(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000), 16'h0000);
        check("shr_out", out, 16'h5F78);
        drive(alu_ins(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), 16'h0000);
        check("xor_out", out, 16'hBEF0);
        drive(alu_ins(4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000), 16'h0000);
        check("f12_out", out, 16'h0000);
        drive(alu_ins(4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000), 16'h0000);
        check("dec_out", out, 16'hBEEF);
        drive(alu_ins(4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000), 16'h0FF0);
        check("and_out", out, 16'h0EF0);
        drive(alu_ins(4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000), 16'h000F);
        check("or_out", out, 16'hBEFF);

        // PC wrap: jump to 0xFFFF, then sequential step wraps to 0
        drive(16'h6000, 16'hFFFF); tick();
        drive(alu_ins(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100), 16'h0000); tick();
        check("jmp_ffff", pc, 16'hFFFF);
        drive(16'h0000, 16'h0000); tick();
        check("pc_wrap", pc, 16'h0000);

        // Asynchronous reset mid-cycle, no clock edge involved
        drive(16'h0123, 16'h0000); tick();
        check("pre_areset_addr", addr, 16'h0123);
        #2;
        reset = 1'b0;
        #1;
        check("areset_pc", pc, 16'h0000);
        check("areset_addr", addr, 16'h0000);
        check("areset_r2", dut.r2_q, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_areset_pc", pc, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
